// File: rtl/rrc_filter.sv
`default_nettype none
// ============================================================================
// Module   : rrc_filter
// Purpose  : 33-tap symmetric root-raised-cosine FIR (roll-off 0.5, 4 sps),
//            one sample per clock, rounded and saturated to the input width.
// Revision : 1.0 - initial release
// ============================================================================
module rrc_filter #(
    parameter int WIDTH = 7
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic signed [WIDTH-1:0] data_in,
    output logic signed [WIDTH-1:0] data_out
);

    localparam int c_TAPS  = 33;
    localparam int c_HALF  = 16;
    localparam int c_ACC_W = WIDTH + 15;
    localparam logic signed [c_ACC_W-1:0] c_SAT_MAX = c_ACC_W'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [c_ACC_W-1:0] c_SAT_MIN = -c_SAT_MAX - c_ACC_W'(1);
    localparam logic signed [c_ACC_W-1:0] c_ROUND   = c_ACC_W'(128);

    logic signed [WIDTH-1:0]   r_x [0:c_TAPS-1];
    logic signed [WIDTH-1:0]   r_out;
    logic signed [c_ACC_W-1:0] w_acc;
    logic signed [c_ACC_W-1:0] w_pre;
    logic signed [c_ACC_W-1:0] w_cf;
    logic signed [c_ACC_W-1:0] w_y;
    logic signed [WIDTH-1:0]   w_sat;

    // Lower half of the symmetric impulse response; c[k] == c[32-k].
    function automatic logic signed [8:0] f_coef(input int k);
        case (k)
            0:       f_coef = -9'sd1;
            1:       f_coef =  9'sd0;
            2:       f_coef =  9'sd1;
            3:       f_coef =  9'sd2;
            4:       f_coef =  9'sd0;
            5:       f_coef = -9'sd2;
            6:       f_coef = -9'sd2;
            7:       f_coef =  9'sd2;
            8:       f_coef =  9'sd5;
            9:       f_coef =  9'sd2;
            10:      f_coef = -9'sd8;
            11:      f_coef = -9'sd18;
            12:      f_coef = -9'sd12;
            13:      f_coef =  9'sd18;
            14:      f_coef =  9'sd65;
            15:      f_coef =  9'sd110;
            default: f_coef =  9'sd128;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < c_TAPS; k++) begin
                r_x[k] <= '0;
            end
        end else begin
            r_x[0] <= data_in;
            for (int k = 1; k < c_TAPS; k++) begin
                r_x[k] <= r_x[k-1];
            end
        end
    end

    // Pre-add mirrored taps, then one multiply per coefficient pair.
    always_comb begin
        w_pre = '0;
        w_cf  = '0;
        w_acc = c_ACC_W'(f_coef(c_HALF)) * c_ACC_W'(r_x[c_HALF]);
        for (int k = 0; k < c_HALF; k++) begin
            w_pre = c_ACC_W'(r_x[k]) + c_ACC_W'(r_x[c_TAPS-1-k]);
            w_cf  = c_ACC_W'(f_coef(k));
            w_acc = w_acc + w_cf * w_pre;
        end
    end

    // Arithmetic shift after +128 gives round-half-up; clamp instead of wrapping.
    always_comb begin
        w_y = (w_acc + c_ROUND) >>> 8;
        if (w_y > c_SAT_MAX) begin
            w_sat = c_SAT_MAX[WIDTH-1:0];
        end else if (w_y < c_SAT_MIN) begin
            w_sat = c_SAT_MIN[WIDTH-1:0];
        end else begin
            w_sat = w_y[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out <= '0;
        end else begin
            r_out <= w_sat;
        end
    end

    assign data_out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_rrc_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rrc_filter
// Purpose  : Directed and reference-model checks for rrc_filter (WIDTH=7).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rrc_filter;

    localparam int WIDTH = 7;

    logic                    clk;
    logic                    rstn;
    logic signed [WIDTH-1:0] data_in;
    logic signed [WIDTH-1:0] data_out;

    int vectors;
    int miscompares;
    int coef [0:32];
    int hist [0:32];

    // Hand-computed round(63*c[k]/256) and round(-64*c[k]/256), k = 0..16.
    int imp_pos [0:16] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, -2, -4, -3, 4, 16, 27, 32};
    int imp_neg [0:16] = '{0, 0, 0, 0, 0, 1, 1, 0, -1, 0, 2, 5, 3, -4, -16, -27, -32};
    int half    [0:16] = '{-1, 0, 1, 2, 0, -2, -2, 2, 5, 2, -8, -18, -12, 18, 65, 110, 128};

    rrc_filter #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One rising edge; the shadow history follows the DUT delay line.
    task automatic tick();
        @(posedge clk);
        if (rstn) begin
            for (int k = 32; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = int'(data_in);
        end
        #1;
    endtask

    function automatic int model_out();
        int acc;
        acc = 0;
        for (int k = 0; k < 33; k++) acc += coef[k] * hist[k];
        acc = (acc + 128) >>> 8;
        if (acc > 63)  acc = 63;
        if (acc < -64) acc = -64;
        return acc;
    endfunction

    task automatic do_reset();
        rstn    = 1'b0;
        data_in = '0;
        for (int k = 0; k < 33; k++) hist[k] = 0;
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        for (int k = 0; k < 33; k++) hist[k] = 0;
        for (int i = 0; i < 8; i++) begin
            data_in = WIDTH'($urandom);
            tick();
            vectors++;
            if (data_out !== 7'sd0) begin
                miscompares++;
                $display("FAIL reset_hold cyc=%0d got=%0d want=0", i, data_out);
            end
        end
        data_in = 7'sd25;
        rstn    = 1'b1;
        tick();
        vectors++;
        if (data_out !== 7'sd0) begin
            miscompares++;
            $display("FAIL reset_first_edge got=%0d want=0", data_out);
        end
    endtask

    task automatic test_impulse(input logic signed [WIDTH-1:0] amp, input bit pos);
        int exp;
        do_reset();
        data_in = amp;
        tick();
        data_in = '0;
        for (int k = 0; k <= 33; k++) begin
            tick();
            if (k == 33) exp = 0;
            else if (pos) exp = imp_pos[(k <= 16) ? k : 32 - k];
            else          exp = imp_neg[(k <= 16) ? k : 32 - k];
            vectors++;
            if (data_out !== 7'(exp)) begin
                miscompares++;
                $display("FAIL impulse amp=%0d tap=%0d got=%0d want=%0d", amp, k, data_out, exp);
            end
        end
    endtask

    task automatic test_dc(input logic signed [WIDTH-1:0] level, input int exp);
        do_reset();
        data_in = level;
        for (int i = 0; i < 36; i++) begin
            tick();
            if (i >= 33) begin
                vectors++;
                if (data_out !== 7'(exp)) begin
                    miscompares++;
                    $display("FAIL dc level=%0d cyc=%0d got=%0d want=%0d", level, i, data_out, exp);
                end
            end
        end
    endtask

    task automatic test_random(input int n);
        int exp;
        for (int i = 0; i < n; i++) begin
            // Bias toward extremes so saturation is exercised.
            if ($urandom_range(3) == 0) data_in = $urandom_range(1) ? 7'sd63 : -7'sd64;
            else                        data_in = WIDTH'($urandom);
            exp = model_out();
            tick();
            vectors++;
            if (data_out !== 7'(exp)) begin
                miscompares++;
                $display("FAIL random idx=%0d got=%0d want=%0d", i, data_out, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        test_random(50);
        #2;
        rstn = 1'b0;
        for (int k = 0; k < 33; k++) hist[k] = 0;
        #1;
        vectors++;
        if (data_out !== 7'sd0) begin
            miscompares++;
            $display("FAIL reset_async got=%0d want=0", data_out);
        end
        data_in = 7'sd63;
        tick();
        vectors++;
        if (data_out !== 7'sd0) begin
            miscompares++;
            $display("FAIL reset_mid_hold got=%0d want=0", data_out);
        end
        rstn = 1'b1;
        test_random(60);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rstn        = 1'b0;
        data_in     = '0;
        for (int k = 0; k <= 16; k++) begin
            coef[k]      = half[k];
            coef[32 - k] = half[k];
        end
        test_reset();
        test_impulse(7'sd63, 1'b1);
        test_impulse(-7'sd64, 1'b0);
        test_dc(7'sd10, 18);
        test_dc(7'sd63, 63);
        test_dc(-7'sd64, -64);
        test_reset_mid();
        do_reset();
        test_random(10000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
